// File: rtl/regs_pkg.sv
// regs_pkg: shared defines and FSM state type for the integer register file.
// Macros: RADDR_WIDTH, RDATA_WIDTH, REG_NUM, ZERO, ZERO_REG, READ_ENABLE,
// WRITE_ENABLE and the state encodings REGS_CLEAR/REGS_RUN.
// Optional feature macro consumed by regs: REGS_DBG_PORT_EN.
`ifndef REGS_DEFINES
`define REGS_DEFINES
`define RADDR_WIDTH  5
`define RDATA_WIDTH  32
`define REG_NUM      32
`define ZERO         {`RDATA_WIDTH{1'b0}}
`define ZERO_REG     5'd0
`define READ_ENABLE  1'b1
`define WRITE_ENABLE 1'b1
`define REGS_CLEAR   1'b0
`define REGS_RUN     1'b1
`endif

package regs_pkg;
  typedef enum logic {CLEAR = `REGS_CLEAR, RUN = `REGS_RUN} state_e;
endpackage

// File: rtl/regs.sv
// regs: 2R1W integer register file with a post-reset zeroing sweep and write-through bypass.
// Ports: clk, rst (sync, active-high); we_i/waddr_i/wdata_i writeback;
// reg1_*/reg2_* combinational read ports; ready_o high once the sweep is done.
// With REGS_DBG_PORT_EN defined, adds dbg_raddr_i/dbg_rdata_o (no bypass).
module regs
  import regs_pkg::*;
#(
  parameter int REG_NUM = `REG_NUM,
  parameter int DW      = `RDATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we_i,
  input  logic [`RADDR_WIDTH-1:0] waddr_i,
  input  logic [DW-1:0]           wdata_i,
  input  logic                    reg1_re_i,
  input  logic [`RADDR_WIDTH-1:0] reg1_raddr_i,
  output logic [DW-1:0]           reg1_rdata_o,
  input  logic                    reg2_re_i,
  input  logic [`RADDR_WIDTH-1:0] reg2_raddr_i,
  output logic [DW-1:0]           reg2_rdata_o,
`ifdef REGS_DBG_PORT_EN
  input  logic [`RADDR_WIDTH-1:0] dbg_raddr_i,
  output logic [DW-1:0]           dbg_rdata_o,
`endif
  output logic                    ready_o
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [DW-1:0] mem_q [REG_NUM];
  logic clr, run, wen;
  assign clr = state_q == CLEAR;
  assign run = state_q == RUN;
  assign wen = run && we_i == `WRITE_ENABLE && waddr_i != `ZERO_REG;
  assign ready_o = run;
  // The sweep leaves CLEAR on the edge that zeroes the last entry; cnt stops there.
  always_comb begin
    cnt_d   = clr ? cnt_q + 5'd1 : cnt_q;
    state_d = (clr && cnt_q == 5'(REG_NUM - 1)) ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= 5'd1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Array has no reset; the CLEAR sweep zeroes it, and entry 0 is never stored.
  always_ff @(posedge clk) begin
    if (clr) mem_q[cnt_q] <= `ZERO;
    else if (wen) mem_q[waddr_i] <= wdata_i;
  end
  assign reg1_rdata_o = (reg1_re_i != `READ_ENABLE || reg1_raddr_i == `ZERO_REG || !run) ? `ZERO :
                        (wen && waddr_i == reg1_raddr_i) ? wdata_i : mem_q[reg1_raddr_i];
  assign reg2_rdata_o = (reg2_re_i != `READ_ENABLE || reg2_raddr_i == `ZERO_REG || !run) ? `ZERO :
                        (wen && waddr_i == reg2_raddr_i) ? wdata_i : mem_q[reg2_raddr_i];
`ifdef REGS_DBG_PORT_EN
  assign dbg_rdata_o = (dbg_raddr_i == `ZERO_REG || !run) ? `ZERO : mem_q[dbg_raddr_i];
`endif
endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 SHALL have parameter REG_NUM, default 32, number of architectural integer registers.
REQ-002 SHALL have parameter DW, default `RDATA_WIDTH (32), register data width.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have ports we_i (input, 1), waddr_i (input, `RADDR_WIDTH), wdata_i (input, DW): writeback request.
REQ-006 SHALL have ports reg1_re_i (input, 1), reg1_raddr_i (input, `RADDR_WIDTH), reg1_rdata_o (output, DW): read port 1, driven by decode.
REQ-007 SHALL have ports reg2_re_i (input, 1), reg2_raddr_i (input, `RADDR_WIDTH), reg2_rdata_o (output, DW): read port 2.
REQ-008 SHALL have port ready_o, output, 1: register file cleared and accepting writes.
REQ-009 SHALL have ports dbg_raddr_i (input, `RADDR_WIDTH) and dbg_rdata_o (output, DW) only when REGS_DBG_PORT_EN is defined.

Function
REQ-010 SHALL contain a two-state FSM: CLEAR (ready_o=0) and RUN (ready_o=1).
REQ-011 SHALL, in CLEAR, write `ZERO into entry cnt each cycle using a 5-bit counter cnt, then increment cnt.
REQ-012 SHALL go CLEAR->RUN on the cycle that writes entry 31; cnt does not wrap back into CLEAR.
REQ-013 SHALL ignore we_i entirely while in CLEAR: no array write, no bypass.
REQ-014 SHALL, in RUN, write wdata_i into entry waddr_i at the clock edge when we_i=`WRITE_ENABLE and waddr_i != `ZERO_REG.
REQ-015 SHALL never store to entry 0; x0 reads always return `ZERO.
REQ-016 SHALL provide combinational reads (zero-cycle latency) on both ports with this priority: re low -> `ZERO; raddr==0 -> `ZERO; state CLEAR -> `ZERO; RUN and we_i and waddr_i==raddr -> wdata_i (write-through bypass); else stored value.
REQ-017 SHALL resolve simultaneous same-address reads on both ports identically, including bypass.
REQ-018 SHALL treat a write and a read to different addresses in the same cycle independently; the read returns the old stored value.

Reset
REQ-019 SHALL, on any clock edge with rst=1, enter CLEAR with cnt=1 and ready_o=0, including when asserted mid-RUN or mid-CLEAR.
REQ-020 SHALL reach ready_o=1 exactly 31 clock edges after the last edge with rst=1.
REQ-021 SHALL not require reset of the array itself; zeroing is done by the CLEAR sweep, so all reads return `ZERO until RUN.

Configuration
REQ-022 SHALL, with REGS_DBG_PORT_EN defined, add a third combinational read port with dbg_rdata_o = stored value of dbg_raddr_i, `ZERO for address 0 or in CLEAR, and no bypass.
REQ-023 SHALL, without REGS_DBG_PORT_EN, omit dbg_raddr_i/dbg_rdata_o from the port list and add no logic.

Structure
REQ-024 SHALL take `RADDR_WIDTH, `RDATA_WIDTH, `ZERO, `ZERO_REG, `READ_ENABLE, `WRITE_ENABLE from defines.v.
REQ-025 SHALL add `REG_NUM and the FSM state encodings `REGS_CLEAR/`REGS_RUN to defines.v.
REQ-026 SHALL be a single module with no sub-module; the read-mux priority logic is duplicated per port.

Verification
REQ-027 SHALL cover reset sweep: rst high 2 cycles, then low -> ready_o=0 for 31 edges, then 1; reg1 read of x5 returns 0 throughout.
REQ-028 SHALL cover write then read: after ready, write x3=0xDEADBEEF -> next cycle reg1 read x3 = 0xDEADBEEF, reg2 read x3 = 0xDEADBEEF.
REQ-029 SHALL cover bypass: in one cycle, we_i=1, waddr_i=7, wdata_i=0x12345678, reg1_raddr_i=7 -> reg1_rdata_o=0x12345678 in that same cycle.
REQ-030 SHALL cover x0: write x0=0xFFFFFFFF -> same-cycle and later reads of x0 = 0; reg2_re_i=0 with raddr=3 -> 0.
REQ-031 SHALL cover mid-run reset: write x10=0xA5A5A5A5, pulse rst one cycle -> ready_o=0 and x10 read = 0; a we_i during CLEAR is dropped; after 31 edges x10 reads 0.
REQ-032 SHALL cover the debug port (REGS_DBG_PORT_EN): write x31=0x0000BEEF -> dbg_raddr_i=31 returns 0x0000BEEF the cycle after the write, with no bypass in the write cycle.
